nv_sdp_rdma_atom_serializer: RTL

- Consumes the packed 4-atom group plus 4-bit valid mask produced by the SDP RDMA unpack stage.
- Emits one atom per cycle toward the SDP data path, skipping unused slots.
- Tracks atom position in the cube using width/height counters and tags each atom with end-of-line and end-of-cube flags.
- Pulses done after the final atom of the configured cube.

---
 rtl/nv_sdp_rdma_atom_serializer_pkg.sv | 30 +++
 rtl/nv_sdp_rdma_atom_cnt.sv | 66 ++++++
 rtl/nv_sdp_rdma_atom_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nv_sdp_rdma_atom_serializer_pkg.sv
// Shared SDP RDMA serializer definitions: mask encodings, FSM states and mask decode helpers.
package nv_sdp_rdma_atom_serializer_pkg;

  localparam int unsigned MASK_W = 4;

  localparam logic [MASK_W-1:0] MASK_1 = 4'h1;
  localparam logic [MASK_W-1:0] MASK_2 = 4'h3;
  localparam logic [MASK_W-1:0] MASK_3 = 4'h7;
  localparam logic [MASK_W-1:0] MASK_4 = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Atom count of a group: position of the highest set mask bit (0 for an empty mask).
  function automatic logic [2:0] mask_atoms(input logic [MASK_W-1:0] m);
    if (m[3])      return 3'd4;
    else if (m[2]) return 3'd3;
    else if (m[1]) return 3'd2;
    else if (m[0]) return 3'd1;
    else           return 3'd0;
  endfunction

  function automatic logic mask_legal(input logic [MASK_W-1:0] m);
    return (m == MASK_1) || (m == MASK_2) || (m == MASK_3) || (m == MASK_4);
  endfunction

endpackage

// File: rtl/nv_sdp_rdma_atom_cnt.sv
// Cube position tracker: latches the cube shape at start and flags end-of-line / end-of-cube
// for the atom currently presented; flags are registered from the next-count values.
module nv_sdp_rdma_atom_cnt #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic [CNT_W-1:0] cfg_height_i,
  input  logic             acc_i,
  output logic             last_w_o,
  output logic             last_h_o
);

  logic [CNT_W-1:0] cfg_w_q, cfg_w_d;
  logic [CNT_W-1:0] cfg_h_q, cfg_h_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic             last_w_q, last_w_d;
  logic             last_h_q, last_h_d;

  always_comb begin
    cfg_w_d = cfg_w_q;
    cfg_h_d = cfg_h_q;
    w_cnt_d = w_cnt_q;
    h_cnt_d = h_cnt_q;
    if (start_i) begin
      cfg_w_d = cfg_width_i;
      cfg_h_d = cfg_height_i;
      w_cnt_d = '0;
      h_cnt_d = '0;
    end else if (acc_i) begin
      if (w_cnt_q == cfg_w_q) begin
        w_cnt_d = '0;
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end else begin
        w_cnt_d = w_cnt_q + CNT_W'(1);
      end
    end
    last_w_d = (w_cnt_d == cfg_w_d);
    last_h_d = last_w_d && (h_cnt_d == cfg_h_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      w_cnt_q  <= '0;
      h_cnt_q  <= '0;
      last_w_q <= 1'b0;
      last_h_q <= 1'b0;
    end else begin
      cfg_w_q  <= cfg_w_d;
      cfg_h_q  <= cfg_h_d;
      w_cnt_q  <= w_cnt_d;
      h_cnt_q  <= h_cnt_d;
      last_w_q <= last_w_d;
      last_h_q <= last_h_d;
    end
  end

  assign last_w_o = last_w_q;
  assign last_h_o = last_h_q;

endmodule

// File: rtl/nv_sdp_rdma_atom_serializer.sv
// SDP RDMA atom serializer: unpacks a masked 4-atom group into one atom per cycle and
// tags each atom with its end-of-line / end-of-cube position.
module nv_sdp_rdma_atom_serializer
  import nv_sdp_rdma_atom_serializer_pkg::*;
#(
  parameter int unsigned AM_DW = 256,
  parameter int unsigned CNT_W = 13
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      op_en,
  input  logic [CNT_W-1:0]          cfg_width,
  input  logic [CNT_W-1:0]          cfg_height,
  input  logic                      inp_pvld,
  output logic                      inp_prdy,
  input  logic [4*AM_DW+4-1:0]      inp_data,
  output logic                      out_pvld,
  input  logic                      out_prdy,
  output logic [AM_DW-1:0]          out_data,
  output logic                      out_last_w,
  output logic                      out_last_h,
  output logic                      done,
  output logic                      err_mask
);

  localparam int unsigned IN_W = MASK_W * AM_DW + MASK_W;

  state_t                       state_q, state_d;
  logic                         hold_vld_q, hold_vld_d;
  logic [1:0]                   sel_q, sel_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [MASK_W-1:0][AM_DW-1:0] atoms_q, atoms_d;
  logic [AM_DW-1:0]             out_data_q, out_data_d;
  logic                         err_q, err_d;
  logic                         done_q, done_d;

  logic [MASK_W-1:0] in_mask_c;
  logic [2:0]        in_cnt_c;
  logic [1:0]        sel_inc_c;
  logic              start_c, out_acc_c, last_slot_c, inp_prdy_c, grp_acc_c;
  logic              last_w, last_h;

  assign in_mask_c   = inp_data[IN_W-1 -: MASK_W];
  assign in_cnt_c    = mask_atoms(in_mask_c);
  assign sel_inc_c   = sel_q + 2'd1;
  assign start_c     = op_en && (state_q == ST_IDLE);
  assign out_acc_c   = hold_vld_q && out_prdy;
  assign last_slot_c = ({1'b0, sel_q} == (cnt_q - 3'd1));
  // A new group may land in the same cycle the last slot drains, but never past cube end.
  assign inp_prdy_c  = (state_q == ST_RUN) &&
                       (!hold_vld_q || (out_acc_c && last_slot_c && !last_h));
  assign grp_acc_c   = inp_pvld && inp_prdy_c;

  nv_sdp_rdma_atom_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk          (nvdla_core_clk),
    .rst_n        (nvdla_core_rstn),
    .start_i      (start_c),
    .cfg_width_i  (cfg_width),
    .cfg_height_i (cfg_height),
    .acc_i        (out_acc_c),
    .last_w_o     (last_w),
    .last_h_o     (last_h)
  );

  always_comb begin
    state_d    = state_q;
    hold_vld_d = hold_vld_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    atoms_d    = atoms_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_en) begin
          state_d = ST_RUN;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (out_acc_c) begin
          if (last_h) begin
            hold_vld_d = 1'b0;
            state_d    = ST_DONE;
            done_d     = 1'b1;
          end else if (last_slot_c) begin
            hold_vld_d = 1'b0;
          end else begin
            sel_d      = sel_inc_c;
            out_data_d = atoms_q[sel_inc_c];
          end
        end
        if (grp_acc_c) begin
          if (!mask_legal(in_mask_c)) err_d = 1'b1;
          atoms_d    = inp_data[MASK_W*AM_DW-1:0];
          cnt_d      = in_cnt_c;
          sel_d      = 2'd0;
          hold_vld_d = (in_cnt_c != 3'd0);
          out_data_d = inp_data[AM_DW-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= ST_IDLE;
      hold_vld_q <= 1'b0;
      sel_q      <= 2'd0;
      cnt_q      <= 3'd0;
      atoms_q    <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      atoms_q    <= atoms_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign inp_prdy   = inp_prdy_c;
  assign out_pvld   = hold_vld_q;
  assign out_data   = out_data_q;
  assign out_last_w = last_w;
  assign out_last_h = last_h;
  assign done       = done_q;
  assign err_mask   = err_q;

endmodule
